// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS control sequencer: fetch/decode/execute/mem/writeback, drives all datapath controls.
// Latency: Moore outputs from the state register. FETCH also gates ir_write/pc_en with mem_ready,
//          and BRANCH gates pc_en with zero.
// Backpressure: memory states hold until mem_ready. After TIMEOUT cycles without it: bus_err, then refetch.
//
// Ports:
//   clk, reset (async, active-high)
//   opcode, zero, mem_ready            : inputs from IR / ALU / memory
//   pc_en, pc_src, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
//   alu_src_a, alu_src_b, alu_op       : datapath controls
//   state                              : current state encoding
//   bus_err, illegal_op                : single-cycle error pulses
module mc_ctrl_fsm #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic [1:0] pc_src,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [3:0] state,
    output logic       bus_err,
    output logic       illegal_op
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        MEMADR = 4'd3,
        MEMRD  = 4'd4,
        MEMWB  = 4'd5,
        MEMWR  = 4'd6,
        EXEC   = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9,
        JUMP   = 4'd10,
        ADDIWB = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LP_MAX  = '1;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             w_wait_st;
    logic             w_timeout;

    assign w_wait_st = (r_state == FETCH) || (r_state == MEMRD) || (r_state == MEMWR);
    // mem_ready takes priority over an expiring count.
    assign w_timeout = w_wait_st && !mem_ready && (r_cnt >= LP_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            // Every exit from a wait state (ready or timeout) clears the count.
            // Non-wait states keep it at zero, so each wait state starts from 0.
            if (w_wait_st && !mem_ready && !w_timeout) begin
                if (r_cnt != LP_MAX) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        pc_en      = 1'b0;
        pc_src     = 2'd0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'd0;
        alu_op     = 2'd0;
        bus_err    = 1'b0;
        illegal_op = 1'b0;

        case (r_state)
            IDLE: begin
                w_next = FETCH;
            end
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'd1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_en    = 1'b1;
                    w_next   = DECODE;
                end else if (w_timeout) begin
                    bus_err = 1'b1;
                    w_next  = FETCH;
                end
            end
            DECODE: begin
                // Speculative branch target into ALUOut.
                alu_src_b = 2'd2;
                case (opcode)
                    OP_LW, OP_SW:     w_next = MEMADR;
                    OP_RTYPE, OP_ADDI: w_next = EXEC;
                    OP_BEQ:           w_next = BRANCH;
                    OP_J:             w_next = JUMP;
                    default: begin
                        illegal_op = 1'b1;
                        w_next     = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                if (opcode == OP_LW) begin
                    w_next = MEMRD;
                end else if (opcode == OP_SW) begin
                    w_next = MEMWR;
                end else begin
                    w_next = FETCH;
                end
            end
            MEMRD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
                if (mem_ready) begin
                    w_next = MEMWB;
                end else if (w_timeout) begin
                    bus_err = 1'b1;
                    w_next  = FETCH;
                end
            end
            MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                w_next     = FETCH;
            end
            MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) begin
                    w_next = FETCH;
                end else if (w_timeout) begin
                    bus_err = 1'b1;
                    w_next  = FETCH;
                end
            end
            EXEC: begin
                alu_src_a = 1'b1;
                if (opcode == OP_ADDI) begin
                    alu_src_b = 2'd2;
                    w_next    = ADDIWB;
                end else begin
                    alu_op = 2'd2;
                    w_next = ALUWB;
                end
            end
            ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                w_next    = FETCH;
            end
            ADDIWB: begin
                reg_write = 1'b1;
                w_next    = FETCH;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'd1;
                pc_src    = 2'd1;
                pc_en     = zero;
                w_next    = FETCH;
            end
            JUMP: begin
                pc_src = 2'd2;
                pc_en  = 1'b1;
                w_next = FETCH;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign state = r_state;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm with a shortened timeout of 4 cycles.
// Inputs change 1 time unit after the rising edge, and outputs are sampled there too.
// Every comparison is an immediate assertion with a hand-computed expected value.
module tb_mc_ctrl_fsm;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [3:0] state;
    logic       bus_err;
    logic       illegal_op;

    int checks   = 0;
    int failures = 0;

    logic [20:0] all_o;
    assign all_o = {pc_en, pc_src, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                    reg_write, alu_src_a, alu_src_b, alu_op, state, bus_err, illegal_op};

    logic [3:0] exp_st [4] = '{4'd2, 4'd7, 4'd8, 4'd1};
    logic       exp_rw [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

    mc_ctrl_fsm #(.TIMEOUT(4), .CNT_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_en      (pc_en),
        .pc_src     (pc_src),
        .iord       (iord),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .state      (state),
        .bus_err    (bus_err),
        .illegal_op (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset     = 1'b1;
        opcode    = 6'h00;
        zero      = 1'b0;
        mem_ready = 1'b0;
        tick();
        tick();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_outs", 32'(all_o), 32'd0);

        // First fetch after reset release, then lw heading into MEMRD.
        reset = 1'b0;
        tick();
        chk("fetch_state", 32'(state), 32'd1);
        chk("fetch_rd", 32'(mem_read), 32'd1);
        chk("fetch_iord", 32'(iord), 32'd0);
        chk("fetch_srcb", 32'(alu_src_b), 32'd1);
        chk("fetch_irw_wait", 32'(ir_write), 32'd0);
        mem_ready = 1'b1;
        opcode    = 6'h23;
        #1;
        chk("fetch_irw", 32'(ir_write), 32'd1);
        chk("fetch_pcen", 32'(pc_en), 32'd1);
        tick();
        chk("dec_state", 32'(state), 32'd2);
        chk("dec_srcb", 32'(alu_src_b), 32'd2);
        tick();
        chk("madr_state", 32'(state), 32'd3);
        chk("madr_srca", 32'(alu_src_a), 32'd1);
        mem_ready = 1'b0;
        tick();
        chk("memrd_state", 32'(state), 32'd4);
        chk("memrd_iord", 32'(iord), 32'd1);
        chk("memrd_rd", 32'(mem_read), 32'd1);
        tick();

        // Reset in the middle of MEMRD.
        reset = 1'b1;
        #1;
        chk("midrst_state", 32'(state), 32'd0);
        chk("midrst_outs", 32'(all_o), 32'd0);
        tick();
        chk("midrst_hold", 32'(all_o), 32'd0);
        reset = 1'b0;
        tick();
        chk("refetch_state", 32'(state), 32'd1);
        chk("refetch_rd", 32'(mem_read), 32'd1);
        chk("refetch_iord", 32'(iord), 32'd0);

        // Fetch timeout with TIMEOUT=4: bus_err on the 4th FETCH cycle.
        chk("to_c1_err", 32'(bus_err), 32'd0);
        tick();
        tick();
        chk("to_c3_err", 32'(bus_err), 32'd0);
        tick();
        chk("to_c4_err", 32'(bus_err), 32'd1);
        chk("to_c4_irw", 32'(ir_write), 32'd0);
        chk("to_c4_pcen", 32'(pc_en), 32'd0);
        chk("to_c4_state", 32'(state), 32'd1);
        tick();
        chk("to_re_state", 32'(state), 32'd1);
        chk("to_re_err", 32'(bus_err), 32'd0);
        tick();
        tick();
        chk("to_re_c3_err", 32'(bus_err), 32'd0);
        tick();
        chk("to_re_c4_err", 32'(bus_err), 32'd1);
        tick();

        // R-type with mem_ready tied high: 1,2,7,8 then back to 1.
        mem_ready = 1'b1;
        opcode    = 6'h00;
        #1;
        chk("r_fetch_irw", 32'(ir_write), 32'd1);
        tick();
        tick();
        chk("r_exec_state", 32'(state), 32'd7);
        chk("r_exec_srcb", 32'(alu_src_b), 32'd0);
        chk("r_exec_op", 32'(alu_op), 32'd2);
        chk("r_exec_rw", 32'(reg_write), 32'd0);
        tick();
        chk("r_wb_state", 32'(state), 32'd8);
        chk("r_wb_rw", 32'(reg_write), 32'd1);
        chk("r_wb_dst", 32'(reg_dst), 32'd1);
        chk("r_wb_m2r", 32'(mem_to_reg), 32'd0);
        tick();
        chk("r_back_state", 32'(state), 32'd1);
        chk("r_back_rw", 32'(reg_write), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("r2_state", 32'(state), 32'(exp_st[i]));
            chk("r2_rw", 32'(reg_write), 32'(exp_rw[i]));
        end

        // addi: EXEC with immediate, then ADDIWB writing rt.
        opcode = 6'h08;
        tick();
        tick();
        chk("addi_exec_state", 32'(state), 32'd7);
        chk("addi_exec_srcb", 32'(alu_src_b), 32'd2);
        chk("addi_exec_op", 32'(alu_op), 32'd0);
        tick();
        chk("addi_wb_state", 32'(state), 32'd11);
        chk("addi_wb_rw", 32'(reg_write), 32'd1);
        chk("addi_wb_dst", 32'(reg_dst), 32'd0);
        tick();
        chk("addi_back", 32'(state), 32'd1);

        // lw with mem_ready arriving on the 4th MEMRD cycle (coincides with timeout).
        opcode = 6'h23;
        tick();
        tick();
        mem_ready = 1'b0;
        tick();
        chk("lw_rd1", 32'(state), 32'd4);
        tick();
        tick();
        chk("lw_rd3", 32'(state), 32'd4);
        tick();
        mem_ready = 1'b1;
        #1;
        chk("lw_rd4_state", 32'(state), 32'd4);
        chk("lw_rd4_err", 32'(bus_err), 32'd0);
        tick();
        chk("lw_wb_state", 32'(state), 32'd5);
        chk("lw_wb_m2r", 32'(mem_to_reg), 32'd1);
        chk("lw_wb_rw", 32'(reg_write), 32'd1);
        chk("lw_wb_dst", 32'(reg_dst), 32'd0);
        tick();
        chk("lw_back", 32'(state), 32'd1);

        // sw completing immediately.
        opcode = 6'h2B;
        tick();
        tick();
        tick();
        chk("sw_state", 32'(state), 32'd6);
        chk("sw_wr", 32'(mem_write), 32'd1);
        chk("sw_iord", 32'(iord), 32'd1);
        chk("sw_rd", 32'(mem_read), 32'd0);
        tick();
        chk("sw_back_state", 32'(state), 32'd1);
        chk("sw_back_wr", 32'(mem_write), 32'd0);

        // sw timing out in MEMWR.
        tick();
        tick();
        mem_ready = 1'b0;
        tick();
        chk("swto_state", 32'(state), 32'd6);
        tick();
        tick();
        tick();
        chk("swto_err", 32'(bus_err), 32'd1);
        chk("swto_wr", 32'(mem_write), 32'd1);
        tick();
        chk("swto_back_state", 32'(state), 32'd1);
        chk("swto_back_wr", 32'(mem_write), 32'd0);
        chk("swto_back_err", 32'(bus_err), 32'd0);
        mem_ready = 1'b1;

        // beq taken then not taken.
        opcode = 6'h04;
        zero   = 1'b1;
        tick();
        tick();
        chk("beq_t_state", 32'(state), 32'd9);
        chk("beq_t_pcen", 32'(pc_en), 32'd1);
        chk("beq_t_pcsrc", 32'(pc_src), 32'd1);
        chk("beq_t_op", 32'(alu_op), 32'd1);
        tick();
        chk("beq_t_back", 32'(state), 32'd1);
        zero = 1'b0;
        tick();
        tick();
        chk("beq_n_state", 32'(state), 32'd9);
        chk("beq_n_pcen", 32'(pc_en), 32'd0);
        chk("beq_n_pcsrc", 32'(pc_src), 32'd1);
        tick();
        chk("beq_n_back", 32'(state), 32'd1);

        // jump.
        opcode = 6'h02;
        tick();
        tick();
        chk("j_state", 32'(state), 32'd10);
        chk("j_pcsrc", 32'(pc_src), 32'd2);
        chk("j_pcen", 32'(pc_en), 32'd1);
        tick();
        chk("j_back", 32'(state), 32'd1);

        // Illegal opcode.
        opcode = 6'h3F;
        tick();
        chk("ill_state", 32'(state), 32'd2);
        chk("ill_pulse", 32'(illegal_op), 32'd1);
        tick();
        chk("ill_back", 32'(state), 32'd1);
        chk("ill_clear", 32'(illegal_op), 32'd0);
        chk("ill_rw", 32'(reg_write), 32'd0);
        chk("ill_wr", 32'(mem_write), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
